sdram_line_fill: RTL

- Fill engine that writes into the 2048x16 byte-enabled cache/buffer RAM from the SDRAM side.
- On a line-fill request it issues one burst read to the SDRAM controller and accepts BURST data beats in critical-word-first, wrap-around order.
- Each beat is written into one RAM write port, and the critical word is also forwarded to the requester the same cycle it is written.
- Sits between the SDRAM controller's burst-read interface and port B of the dual-port RAM.

---
 rtl/sdram_line_fill_if.sv | 36 +++
 rtl/sdram_line_fill.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sdram_line_fill_if.sv
// Signal bundle for the SDRAM line-fill engine.
// Covers the requester handshake, the SDRAM burst-read port and the RAM write port.
interface sdram_line_fill_if #(
    parameter int AW  = 11,
    parameter int SAW = 22
);
    logic           fill_req;
    logic [SAW-1:0] fill_addr;
    logic           fill_busy;
    logic           fill_done;
    logic           crit_valid;
    logic [15:0]    crit_data;
    logic           sdr_req;
    logic [SAW-1:0] sdr_addr;
    logic           sdr_ack;
    logic           sdr_dv;
    logic [15:0]    sdr_data;
    logic           ram_wren;
    logic [1:0]     ram_byteena;
    logic [AW-1:0]  ram_address;
    logic [15:0]    ram_data;

    // Fill engine view
    modport master (
        input  fill_req, fill_addr, sdr_ack, sdr_dv, sdr_data,
        output fill_busy, fill_done, crit_valid, crit_data,
               sdr_req, sdr_addr, ram_wren, ram_byteena, ram_address, ram_data
    );

    // Requester / SDRAM controller / RAM view
    modport slave (
        output fill_req, fill_addr, sdr_ack, sdr_dv, sdr_data,
        input  fill_busy, fill_done, crit_valid, crit_data,
               sdr_req, sdr_addr, ram_wren, ram_byteena, ram_address, ram_data
    );
endinterface

// File: rtl/sdram_line_fill.sv
// Line-fill engine: one SDRAM burst read per request, beats written critical-word-first
// with wrap-around into the RAM write port; the critical word is forwarded as it is written.
module sdram_line_fill #(
    parameter int AW    = 11,
    parameter int SAW   = 22,
    parameter int LW    = 2,
    parameter int BURST = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    sdram_line_fill_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter has one spare bit so "all beats taken" is distinct from beat 0.
    localparam logic [LW:0] FULL_CNT = BURST[LW:0];

    state_t         state_r, state_s;
    logic [AW-1:0]  addr_r, addr_s;
    logic [LW:0]    cnt_r, cnt_s;
    logic           accept_s;
    logic [LW-1:0]  low_s;

    logic           fill_busy_r, fill_busy_s;
    logic           fill_done_r, fill_done_s;
    logic           crit_valid_r, crit_valid_s;
    logic [15:0]    crit_data_r, crit_data_s;
    logic           sdr_req_r, sdr_req_s;
    logic [SAW-1:0] sdr_addr_r, sdr_addr_s;
    logic           ram_wren_r, ram_wren_s;
    logic [1:0]     ram_byteena_r, ram_byteena_s;
    logic [AW-1:0]  ram_address_r, ram_address_s;
    logic [15:0]    ram_data_r, ram_data_s;

    // Next-state and next-output logic
    always_comb begin
        state_s       = state_r;
        addr_s        = addr_r;
        cnt_s         = cnt_r;
        accept_s      = 1'b0;
        sdr_addr_s    = sdr_addr_r;
        crit_valid_s  = 1'b0;
        crit_data_s   = crit_data_r;
        ram_wren_s    = 1'b0;
        ram_byteena_s = 2'b00;
        ram_address_s = ram_address_r;
        ram_data_s    = ram_data_r;
        low_s         = addr_r[LW-1:0] + cnt_r[LW-1:0];

        case (state_r)
            IDLE: begin
                if (bus.fill_req) begin
                    addr_s     = bus.fill_addr[AW-1:0];
                    sdr_addr_s = bus.fill_addr;
                    cnt_s      = {(LW+1){1'b0}};
                    state_s    = REQ;
                end else begin
                    state_s    = IDLE;
                end
            end
            REQ: begin
                if (bus.sdr_ack) begin
                    accept_s = bus.sdr_dv;
                    state_s  = DATA;
                end else begin
                    state_s  = REQ;
                end
            end
            DATA: begin
                if (cnt_r == FULL_CNT) begin
                    state_s  = DONE;
                end else begin
                    accept_s = bus.sdr_dv;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (accept_s) begin
            ram_wren_s    = 1'b1;
            ram_byteena_s = 2'b11;
            ram_address_s = {addr_r[AW-1:LW], low_s};
            ram_data_s    = bus.sdr_data;
            cnt_s         = cnt_r + {{LW{1'b0}}, 1'b1};
            if (cnt_r == {(LW+1){1'b0}}) begin
                crit_valid_s = 1'b1;
                crit_data_s  = bus.sdr_data;
            end else begin
                crit_valid_s = 1'b0;
            end
        end else begin
            ram_wren_s = 1'b0;
        end

        // Status outputs follow the state being entered so they line up with it
        sdr_req_s   = (state_s == REQ);
        fill_busy_s = (state_s != IDLE);
        fill_done_s = (state_s == DONE);
    end

    // State, line context and all outputs are registered here
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            addr_r        <= {AW{1'b0}};
            cnt_r         <= {(LW+1){1'b0}};
            fill_busy_r   <= 1'b0;
            fill_done_r   <= 1'b0;
            crit_valid_r  <= 1'b0;
            crit_data_r   <= 16'h0000;
            sdr_req_r     <= 1'b0;
            sdr_addr_r    <= {SAW{1'b0}};
            ram_wren_r    <= 1'b0;
            ram_byteena_r <= 2'b00;
            ram_address_r <= {AW{1'b0}};
            ram_data_r    <= 16'h0000;
        end else begin
            state_r       <= state_s;
            addr_r        <= addr_s;
            cnt_r         <= cnt_s;
            fill_busy_r   <= fill_busy_s;
            fill_done_r   <= fill_done_s;
            crit_valid_r  <= crit_valid_s;
            crit_data_r   <= crit_data_s;
            sdr_req_r     <= sdr_req_s;
            sdr_addr_r    <= sdr_addr_s;
            ram_wren_r    <= ram_wren_s;
            ram_byteena_r <= ram_byteena_s;
            ram_address_r <= ram_address_s;
            ram_data_r    <= ram_data_s;
        end
    end

    assign bus.fill_busy   = fill_busy_r;
    assign bus.fill_done   = fill_done_r;
    assign bus.crit_valid  = crit_valid_r;
    assign bus.crit_data   = crit_data_r;
    assign bus.sdr_req     = sdr_req_r;
    assign bus.sdr_addr    = sdr_addr_r;
    assign bus.ram_wren    = ram_wren_r;
    assign bus.ram_byteena = ram_byteena_r;
    assign bus.ram_address = ram_address_r;
    assign bus.ram_data    = ram_data_r;
endmodule
